// File: rtl/audio_pwm_scheduler.sv
// Audio PWM scheduler: a CPU-fed sample FIFO drives a PWM output.
// A new duty code is taken from the FIFO only at a PWM frame boundary.
module audio_pwm_scheduler #(
   parameter int PWM_BITS          = 10,
   parameter int CLOCKS_PER_SAMPLE = 2835,
   parameter int FIFO_DEPTH        = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic [PWM_BITS-1:0]           sample_in,
   input  logic                          sample_in_valid,
   output logic                          sample_in_ready,
   input  logic                          clear_underflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [15:0]                   underflow_count,
   output logic                          frame_start,
   output logic                          aud_pwm,
   output logic                          aud_sd
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SC_W  = $clog2(CLOCKS_PER_SAMPLE);
   localparam logic [PWM_BITS-1:0] MIDSCALE = {1'b1, {(PWM_BITS-1){1'b0}}};

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state_q, state_d;
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [SC_W-1:0]     sample_cnt_q, sample_cnt_d;
   logic                sample_due_q, sample_due_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic                aud_pwm_q, aud_pwm_d;
   logic                frame_start_q, frame_start_d;
   logic [15:0]         underflow_q, underflow_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [PWM_BITS-1:0] mem_q [FIFO_DEPTH];

   logic push, pop, fetch, fifo_empty, frame_end, sample_wrap;

   assign sample_in_ready = (count_q != CNT_W'(FIFO_DEPTH));
   assign push            = sample_in_valid && sample_in_ready;
   assign fifo_empty      = (count_q == '0);
   assign frame_end       = (pwm_cnt_q == '1);
   assign sample_wrap     = (sample_cnt_q == SC_W'(CLOCKS_PER_SAMPLE - 1));
   // A due sample is served at the end of the current frame, so the duty
   // change always lands on pwm_cnt = 0.
   assign fetch           = enable && frame_end && (sample_due_q || sample_wrap);
   assign pop             = fetch && !fifo_empty;

   always_comb begin
      state_d       = enable ? RUN : IDLE;
      pwm_cnt_d     = '0;
      sample_cnt_d  = '0;
      sample_due_d  = 1'b0;
      aud_pwm_d     = 1'b0;
      frame_start_d = 1'b0;
      duty_d        = duty_q;
      underflow_d   = underflow_q;
      if (enable) begin
         pwm_cnt_d     = pwm_cnt_q + PWM_BITS'(1);
         sample_cnt_d  = sample_wrap ? '0 : sample_cnt_q + SC_W'(1);
         aud_pwm_d     = (pwm_cnt_q < duty_q);
         frame_start_d = (pwm_cnt_q == '0);
         sample_due_d  = fetch ? 1'b0 : (sample_due_q || sample_wrap);
      end
      if (pop) begin
         duty_d = mem_q[rd_ptr_q];
      end
      if (clear_underflow) begin
         underflow_d = '0;
      end else if (fetch && fifo_empty && underflow_q != 16'hFFFF) begin
         underflow_d = underflow_q + 16'd1;
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         pwm_cnt_q     <= '0;
         sample_cnt_q  <= '0;
         sample_due_q  <= 1'b0;
         duty_q        <= MIDSCALE;
         aud_pwm_q     <= 1'b0;
         frame_start_q <= 1'b0;
         underflow_q   <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         state_q       <= state_d;
         pwm_cnt_q     <= pwm_cnt_d;
         sample_cnt_q  <= sample_cnt_d;
         sample_due_q  <= sample_due_d;
         duty_q        <= duty_d;
         aud_pwm_q     <= aud_pwm_d;
         frame_start_q <= frame_start_d;
         underflow_q   <= underflow_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
      end
   end

   // Sample storage needs no reset; occupancy alone decides what is valid.
   for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk) begin
         if (push && wr_ptr_q == PTR_W'(gi)) begin
            mem_q[gi] <= sample_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (CLOCKS_PER_SAMPLE >= (1 << PWM_BITS))
            else $error("CLOCKS_PER_SAMPLE is shorter than one PWM frame");
      end
   end

   assign fifo_count      = count_q;
   assign underflow_count = underflow_q;
   assign frame_start     = frame_start_q;
   assign aud_pwm         = aud_pwm_q;
   assign aud_sd          = (state_q == RUN);
endmodule

// File: doc/audio_pwm_scheduler.md
Name: audio_pwm_scheduler

Overview:
- Sequences audio samples from the CPU into the on-board PWM audio output (aud_pwm / aud_sd).
- A CPU-side valid/ready port fills a small sample FIFO.
- A sample-rate divider marks when a new sample is due. The new duty is applied only at a PWM frame boundary, so the waveform never glitches.
- Sits between the CPU MMIO decode and the z1top audio pins. Replaces software bit-banging of the PWM pin.

Parameters:
- PWM_BITS, 10: duty/sample width. PWM frame length = 2^PWM_BITS clocks.
- CLOCKS_PER_SAMPLE, 2835: clocks per audio sample (about 44.1 kHz at 125 MHz). Must be >= 2^PWM_BITS (simulation assertion).
- FIFO_DEPTH, 8: sample FIFO entries. Power of two, >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  1 = playback running
- sample_in  in  PWM_BITS  unsigned duty code
- sample_in_valid  in  1  CPU offers sample
- sample_in_ready  out  1  FIFO can accept
- clear_underflow  in  1  clears underflow_count
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
- underflow_count  out  16  saturating count of missed samples
- frame_start  out  1  one-cycle pulse at PWM frame start
- aud_pwm  out  1  PWM output
- aud_sd  out  1  amplifier enable; equals registered enable

Behaviour:
- Reset (rst=1 at a clk edge), regardless of other inputs:
  - FIFO empty; fifo_count=0; sample_in_ready=1.
  - pwm_cnt=0; sample_cnt=0; sample_due=0.
  - duty_reg=2^(PWM_BITS-1) (midscale).
  - aud_pwm=0, aud_sd=0, frame_start=0, underflow_count=0.
  - Reset mid-operation discards FIFO contents.
- Push:
  - sample_in_ready = (fifo_count != FIFO_DEPTH), combinational, independent of enable, so the CPU can prefill.
  - A push happens on a cycle with valid && ready. Data is written at the tail.
- States:
  - IDLE (enable=0): pwm_cnt and sample_cnt held at 0; sample_due=0; aud_pwm=0; aud_sd=0; frame_start=0.
  - IDLE: FIFO, duty_reg and underflow_count are preserved.
  - IDLE -> RUN when enable=1 is sampled. RUN -> IDLE when enable=0 is sampled; aud_pwm=0 on the next cycle, even mid-frame.
- RUN:
  - pwm_cnt increments every cycle and wraps 2^PWM_BITS-1 -> 0.
  - sample_cnt increments and wraps CLOCKS_PER_SAMPLE-1 -> 0. On wrap, sample_due is set.
  - aud_pwm is registered: aud_pwm(t+1) = (pwm_cnt(t) < duty_reg(t)).
    - duty 0 gives constant 0.
    - duty 2^PWM_BITS-1 gives high for 2^PWM_BITS-1 of 2^PWM_BITS cycles.
  - frame_start(t+1) = (pwm_cnt(t)==0).
  - aud_sd=1.
- Frame boundary (pwm_cnt==2^PWM_BITS-1) with sample_due set, or with sample_cnt wrapping on the same cycle:
  - FIFO non-empty: pop head into duty_reg; the new duty is effective from pwm_cnt=0. Clear sample_due.
  - FIFO empty: duty_reg unchanged; underflow_count += 1, saturating at 16'hFFFF; clear sample_due.
- Simultaneous events:
  - Push and pop on the same cycle: fifo_count unchanged. Data stays ordered.
  - Pop on an empty FIFO while a push arrives on the same cycle: counts as an underflow. The pushed sample is stored.
  - Push when full: not accepted, because ready is 0.
- clear_underflow: has priority over an increment on the same cycle; result is 0.
- Pointers: wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.

Test Plan:
All scenarios use PWM_BITS=4, CLOCKS_PER_SAMPLE=32, FIFO_DEPTH=4.
1. Reset: hold rst 5 cycles with valid=1 -> fifo_count=0, ready=1, aud_pwm=0, aud_sd=0, underflow_count=0. The first enabled frame shows midscale: aud_pwm high 8 of 16 cycles.
2. Prefill: enable=0, push 4, 8, 0, 15 -> ready=0 after the 4th push. A 5th valid (value 3) is not accepted and fifo_count stays 4.
3. Playback: with the FIFO from scenario 2, set enable=1.
   - Duty 4 appears at the first boundary after sample_cnt wraps: 4 of 16 high per frame.
   - Duty 8 follows 32 cycles later, then duty 0 (aud_pwm constant 0), then duty 15 (15 of 16 high).
   - frame_start pulses every 16 cycles.
4. Underflow: empty FIFO, enable=1 for 3 sample periods -> underflow_count=3 and duty stays at its last value. Assert clear_underflow on the cycle of a 4th underflow -> count reads 0.
5. Disable mid-frame: deassert enable at pwm_cnt=5 while aud_pwm=1 -> next cycle aud_pwm=0 and aud_sd=0, fifo_count unchanged. On re-enable, frame_start occurs 1 cycle after pwm_cnt=0.
6. Reset mid-operation: rst with FIFO=3 during RUN -> all outputs at reset values next cycle, fifo_count=0, duty midscale.
